if_stage_fetch: RTL and testbench

//   Instruction fetch stage and IF/ID pipeline register: the producer of Instruction for the decode stage.

---
 rtl/if_stage_fetch.sv | 128 ++++++++++++
 tb/tb_if_stage_fetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_fetch.sv
// Instruction fetch stage with IF/ID pipeline register.
// It issues one imem request at a time and handles hazard freeze and branch redirect.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_Address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic        inst_valid
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic [31:0] disc_addr_q;
  logic [31:0] hold_inst_q;
  logic [31:0] hold_pc_q;

  assign pc_next = pc_q + PC_STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (Branch_taken) begin
          state_d = imem_ack ? FETCH : DISCARD;
        end else if (imem_ack && freeze) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (Branch_taken || !freeze) begin
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // While discarding, the abandoned request keeps its address until memory acks it.
  always_comb begin
    imem_req  = (state_q != HOLD);
    imem_addr = (state_q == DISCARD) ? disc_addr_q : pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      disc_addr_q <= RESET_PC;
      hold_inst_q <= NOP_INST;
      hold_pc_q   <= 32'h0;
      Instruction <= NOP_INST;
      PC          <= 32'h0;
      inst_valid  <= 1'b0;
    end else if (Branch_taken) begin
      pc_q <= Branch_Address;
      if (state_q != DISCARD) begin
        hold_inst_q <= NOP_INST;
        hold_pc_q   <= 32'h0;
        Instruction <= NOP_INST;
        PC          <= 32'h0;
        inst_valid  <= 1'b0;
      end
      if (state_q == FETCH && !imem_ack) begin
        disc_addr_q <= pc_q;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            pc_q <= pc_next;
            if (freeze) begin
              hold_inst_q <= imem_rdata;
              hold_pc_q   <= pc_next;
            end else begin
              Instruction <= imem_rdata;
              PC          <= pc_next;
              inst_valid  <= 1'b1;
            end
          end else if (!freeze) begin
            Instruction <= NOP_INST;
            inst_valid  <= 1'b0;
          end
        end
        HOLD: begin
          if (!freeze) begin
            Instruction <= hold_inst_q;
            PC          <= hold_pc_q;
            inst_valid  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Testbench for if_stage_fetch: a latency-programmable memory model feeds a scoreboard of expected IF/ID words.
// Directed scenarios cover freeze, redirect, discard, wrap and reset, and a short random phase follows them.
module tb_if_stage_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        Branch_taken;
  logic [31:0] Branch_Address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic        inst_valid;

  int tests_run;
  int tests_failed;
  int lat;
  int wait_cnt;

  logic [63:0] exp_q[$];
  logic        drop_pending;
  logic        held;

  logic        s_freeze, s_branch, s_req, s_ack, p_valid;
  logic [31:0] s_baddr, s_addr, s_rdata, p_inst, p_pc;

  if_stage_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .Branch_taken   (Branch_taken),
    .Branch_Address (Branch_Address),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .Instruction    (Instruction),
    .PC             (PC),
    .inst_valid     (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory acks after 'lat' cycles of a held request; it shares rst with the DUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 0;
    end else if (imem_ack) begin
      wait_cnt <= 0;
    end else if (imem_req) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = imem_addr ^ KEY;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        chk_pc;
    logic        accepted;
    logic        was_drop;
    logic [63:0] item;
    #4;
    s_freeze = freeze;
    s_branch = Branch_taken;
    s_baddr  = Branch_Address;
    s_req    = imem_req;
    s_ack    = imem_ack;
    s_addr   = imem_addr;
    s_rdata  = imem_rdata;
    p_inst   = Instruction;
    p_pc     = PC;
    p_valid  = inst_valid;
    @(posedge clk);
    #1;
    was_drop = drop_pending;
    accepted = s_ack && !s_branch && !was_drop;
    if (s_ack) drop_pending = 1'b0;
    if (accepted) exp_q.push_back({s_rdata, s_addr + 32'd4});
    chk_pc = 1'b1;
    if (s_branch) begin
      e_inst  = NOP;
      e_pc    = 32'h0;
      e_valid = 1'b0;
      if (held) begin
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        held = 1'b0;
      end
      if (s_req && !s_ack) drop_pending = 1'b1;
    end else if (s_freeze) begin
      e_inst  = p_inst;
      e_pc    = p_pc;
      e_valid = p_valid;
      if (accepted) held = 1'b1;
    end else if (held || accepted) begin
      held = 1'b0;
      if (exp_q.size() == 0) begin
        checkOutput("sb_empty", 32'd0, 32'd1);
        e_inst  = NOP;
        e_pc    = 32'h0;
        e_valid = 1'b1;
      end else begin
        item    = exp_q.pop_front();
        e_inst  = item[63:32];
        e_pc    = item[31:0];
        e_valid = 1'b1;
      end
    end else begin
      e_inst  = NOP;
      e_pc    = 32'h0;
      e_valid = 1'b0;
      chk_pc  = 1'b0;
    end
    checkOutput("inst_valid", {31'b0, inst_valid}, {31'b0, e_valid});
    checkOutput("instruction", Instruction, e_inst);
    if (chk_pc) checkOutput("pc_out", PC, e_pc);
    if (s_branch && (s_ack || !s_req)) checkOutput("redirect_addr", imem_addr, s_baddr);
    else if (s_req && !s_ack) checkOutput("addr_stable", imem_addr, s_addr);
    else if (accepted) checkOutput("addr_step", imem_addr, s_addr + 32'd4);
    checkOutput("imem_req", {31'b0, imem_req}, {31'b0, !held});
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic frz, input logic br, input logic [31:0] baddr);
    freeze         = frz;
    Branch_taken   = br;
    Branch_Address = baddr;
    step();
    freeze         = 1'b0;
    Branch_taken   = 1'b0;
    Branch_Address = 32'h0;
  endtask

  task automatic wait_for_addr(input logic [31:0] target);
    int n = 0;
    while (imem_addr !== target && n < 60) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      n++;
    end
    checkOutput("wait_addr", imem_addr, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_inst"}, Instruction, NOP);
    checkOutput({tag, "_pc"}, PC, 32'h0);
    checkOutput({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
    checkOutput({tag, "_addr"}, imem_addr, 32'h0);
    checkOutput({tag, "_req"}, {31'b0, imem_req}, 32'd1);
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    lat            = 0;
    rst            = 1'b1;
    freeze         = 1'b0;
    Branch_taken   = 1'b0;
    Branch_Address = 32'h0;
    drop_pending   = 1'b0;
    held           = 1'b0;

    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("first_inst", Instruction, 32'hA5A5_0000);
    checkOutput("first_pc", PC, 32'h4);

    // Freeze across an ack at 0x10: word 0x0C stays visible, 0x10 follows.
    wait_for_addr(32'h10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("freeze_hold", Instruction, 32'hA5A5_000C);
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("hold_release", Instruction, 32'hA5A5_0010);

    // Redirect while a slow request to 0x20 is outstanding.
    lat = 2;
    wait_for_addr(32'h20);
    applyStimulus(1'b0, 1'b1, 32'h100);
    checkOutput("discard_addr_hold", imem_addr, 32'h20);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("refetch_addr", imem_addr, 32'h100);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("target_inst", Instruction, 32'hA5A5_0100);
    checkOutput("target_valid", {31'b0, inst_valid}, 32'd1);

    // Branch together with freeze while HOLD holds word 0x104.
    lat = 0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h200);
    checkOutput("hold_branch_addr", imem_addr, 32'h200);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("hold_branch_inst", Instruction, 32'hA5A5_0200);

    // PC wrap at the top of the address space.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    checkOutput("wrap_target", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr", imem_addr, 32'h0);
    checkOutput("wrap_pc", PC, 32'h0);
    checkOutput("wrap_inst", Instruction, 32'h5A5A_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // Asynchronous reset while discarding.
    lat = 3;
    applyStimulus(1'b0, 1'b1, 32'h300);
    checkOutput("discard_old_addr", imem_addr, 32'h4);
    applyStimulus(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    drop_pending = 1'b0;
    held         = 1'b0;
    lat          = 0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("post_reset_addr", imem_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("post_reset_inst", Instruction, 32'hA5A5_0000);

    for (int i = 0; i < 40; i++) begin
      lat = $urandom_range(0, 2);
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                    {20'h0, 10'($urandom_range(0, 1023)), 2'b00});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
